// File: rtl/pci_pkg.sv
// pci_pkg: shared types and constants for the PCI bus-role controller.
//   pci_state_e    - controller state encoding (idle, address, data, turnaround, slave)
//   DEVSEL_TIMEOUT - DATA cycle on which a master abort is declared if DEVSEL# is still high
package pci_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StTurn,
        StSlave
    } pci_state_e;

    localparam int unsigned DEVSEL_TIMEOUT = 5;

endpackage

// File: rtl/pci_phase_counter.sv
// pci_phase_counter: remaining-data-phase counter for a master burst.
//   clk, rst   - bus clock, synchronous active-high reset
//   load, len  - load the requested length (0 -> 1, >MAX_BURST -> MAX_BURST)
//   dec        - one data phase completed
//   rem        - phases still to transfer
//   last       - rem == 1 (current phase is the final one)
//   next_last  - rem == 2 (a completion now makes the next phase the final one)
module pci_phase_counter
    import pci_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] rem,
    output logic             last,
    output logic             next_last
);

    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] len_clamped;

    always_comb begin
        len_clamped = len;
        if (len == '0) begin
            len_clamped = CNT_W'(1);
        end else if (len > CNT_W'(MAX_BURST)) begin
            len_clamped = CNT_W'(MAX_BURST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
        end else if (load) begin
            rem_q <= len_clamped;
        end else if (dec && (rem_q != '0)) begin
            rem_q <= rem_q - 1'b1;
        end
    end

    assign rem       = rem_q;
    assign last      = (rem_q == CNT_W'(1));
    // Integer compare keeps this correct when CNT_W is too narrow to hold 2.
    assign next_last = (int'(rem_q) == 2);

endmodule

// File: rtl/pci_role_ctrl.sv
// pci_role_ctrl: PCI bus-role controller and FRAME#/IRDY# sequencer.
// Chooses initiator or target role from GNT#/IDSEL, runs a master burst of up
// to MAX_BURST data phases and pulses DONE when the master transaction ends.
// Optional master-abort timer: define PCI_MASTER_ABORT_EN.
//   CLK, RST          - bus clock, synchronous active-high reset
//   REQ, BURST_LEN    - start a master transaction of BURST_LEN phases (IDLE only)
//   GNT, IDSEL        - arbiter grant (active low), target select (active high)
//   TRDY, DEVSEL      - target ready / target claim (active low)
//   SLV_DONE          - target datapath finished, leave SLAVE
//   S_M               - 1 = master, 0 = slave/idle
//   FRAME, IRDY       - FRAME#, IRDY# (active low)
//   BUSY, DONE, ABORT - not idle; end-of-master pulse; master-abort pulse
// All outputs are registered and aligned with the state they describe.
module pci_role_ctrl
    import pci_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [CNT_W-1:0] BURST_LEN,
    input  logic             GNT,
    input  logic             IDSEL,
    input  logic             TRDY,
    input  logic             DEVSEL,
    input  logic             SLV_DONE,
    output logic             S_M,
    output logic             FRAME,
    output logic             IRDY,
    output logic             BUSY,
    output logic             DONE,
    output logic             ABORT
);

    pci_state_e state_q;
    logic s_m_q, frame_q, irdy_q, busy_q, done_q, abort_q;

    logic             load, dec;
    logic [CNT_W-1:0] rem;
    logic             last, next_last;
    logic             abort_now, abort_warn;

    // Master request wins over target select.
    assign load = (state_q == StIdle) && REQ && !GNT;
    // IRDY# is low throughout DATA, so TRDY# low completes a phase.
    assign dec  = (state_q == StData) && !TRDY && !abort_now;

    pci_phase_counter #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_phase_counter (
        .clk       (CLK),
        .rst       (RST),
        .load      (load),
        .dec       (dec),
        .len       (BURST_LEN),
        .rem       (rem),
        .last      (last),
        .next_last (next_last)
    );

`ifdef PCI_MASTER_ABORT_EN
    logic [2:0] dev_cnt_q;
    logic       claimed_q;

    // Counts DATA cycles without a DEVSEL# claim; once claimed, never aborts.
    always_ff @(posedge CLK) begin
        if (RST || (state_q != StData)) begin
            dev_cnt_q <= '0;
            claimed_q <= 1'b0;
        end else if (!DEVSEL) begin
            dev_cnt_q <= '0;
            claimed_q <= 1'b1;
        end else if (!claimed_q && (dev_cnt_q != 3'(DEVSEL_TIMEOUT - 1))) begin
            dev_cnt_q <= dev_cnt_q + 3'd1;
        end
    end

    assign abort_now  = (state_q == StData) && DEVSEL && !claimed_q &&
                        (dev_cnt_q == 3'(DEVSEL_TIMEOUT - 1));
    // One cycle early so FRAME# is already high on the aborting cycle.
    assign abort_warn = (state_q == StData) && DEVSEL && !claimed_q &&
                        (dev_cnt_q == 3'(DEVSEL_TIMEOUT - 2));
`else
    logic unused_devsel;
    assign unused_devsel = DEVSEL;
    assign abort_now     = 1'b0;
    assign abort_warn    = 1'b0;
`endif

    logic [CNT_W-1:0] unused_rem;
    assign unused_rem = rem;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            s_m_q   <= 1'b0;
            frame_q <= 1'b1;
            irdy_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (REQ && !GNT) begin
                        state_q <= StAddr;
                        s_m_q   <= 1'b1;
                        frame_q <= 1'b0;
                        irdy_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (IDSEL && GNT) begin
                        state_q <= StSlave;
                        busy_q  <= 1'b1;
                    end
                end
                StAddr: begin
                    state_q <= StData;
                    irdy_q  <= 1'b0;
                    frame_q <= last;
                end
                StData: begin
                    if (abort_now) begin
                        state_q <= StTurn;
                        frame_q <= 1'b1;
                        irdy_q  <= 1'b1;
                        done_q  <= 1'b1;
                        abort_q <= 1'b1;
                    end else begin
                        if (!TRDY) begin
                            if (last) begin
                                state_q <= StTurn;
                                frame_q <= 1'b1;
                                irdy_q  <= 1'b1;
                                done_q  <= 1'b1;
                            end else begin
                                frame_q <= next_last;
                            end
                        end
                        if (abort_warn) begin
                            frame_q <= 1'b1;
                        end
                    end
                end
                StTurn: begin
                    state_q <= StIdle;
                    s_m_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                StSlave: begin
                    if (SLV_DONE) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign S_M   = s_m_q;
    assign FRAME = frame_q;
    assign IRDY  = irdy_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign ABORT = abort_q;

endmodule

// File: tb/tb_pci_role_ctrl.sv
// Bench for pci_role_ctrl. Output vectors are {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
// input vectors are {REQ, GNT, IDSEL, SLV_DONE, TRDY}, applied 1ns after an edge and
// therefore acting on the state shown in that same cycle.
module tb_pci_role_ctrl;

    localparam int unsigned MAX_BURST = 8;
    localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1);

    logic             CLK = 1'b0;
    logic             RST;
    logic             REQ;
    logic [CNT_W-1:0] BURST_LEN;
    logic             GNT;
    logic             IDSEL;
    logic             TRDY;
    logic             DEVSEL;
    logic             SLV_DONE;
    logic             S_M, FRAME, IRDY, BUSY, DONE, ABORT;

    int compared   = 0;
    int mismatched = 0;

    pci_role_ctrl #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .BURST_LEN (BURST_LEN),
        .GNT       (GNT),
        .IDSEL     (IDSEL),
        .TRDY      (TRDY),
        .DEVSEL    (DEVSEL),
        .SLV_DONE  (SLV_DONE),
        .S_M       (S_M),
        .FRAME     (FRAME),
        .IRDY      (IRDY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ABORT     (ABORT)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic [4:0] v);
        {REQ, GNT, IDSEL, SLV_DONE, TRDY} = v;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        RST = 1'b1;
        drive(5'b01001);
        BURST_LEN = '0;
        DEVSEL = 1'b0;
        tick();
        tick();
        obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
        compared++;
        if (obs !== 6'b011000) begin
            mismatched++;
            $display("FAIL reset_init: got %b expected %b", obs, 6'b011000);
        end
        RST = 1'b0;
        // Start a 4-phase burst, then reset in the second DATA cycle.
        BURST_LEN = CNT_W'(4);
        drive(5'b10000);
        tick();
        obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
        compared++;
        if (obs !== 6'b101100) begin
            mismatched++;
            $display("FAIL reset_addr: got %b expected %b", obs, 6'b101100);
        end
        drive(5'b01000);
        tick();
        tick();
        obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
        compared++;
        if (obs !== 6'b100100) begin
            mismatched++;
            $display("FAIL reset_data: got %b expected %b", obs, 6'b100100);
        end
        RST = 1'b1;
        tick();
        obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
        compared++;
        if (obs !== 6'b011000) begin
            mismatched++;
            $display("FAIL reset_mid_data: got %b expected %b", obs, 6'b011000);
        end
        RST = 1'b0;
        drive(5'b01001);
        tick();
        obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
        compared++;
        if (obs !== 6'b011000) begin
            mismatched++;
            $display("FAIL reset_after: got %b expected %b", obs, 6'b011000);
        end
    endtask

    task automatic test_single();
        logic [5:0] ev [4];
        logic [4:0] iv [4];
        logic [5:0] obs;
        ev = '{6'b101100, 6'b110100, 6'b111110, 6'b011000};
        iv = '{5'b01001, 5'b01000, 5'b01001, 5'b01001};
        BURST_LEN = CNT_W'(1);
        drive(5'b10001);
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
            compared++;
            if (obs !== ev[i]) begin
                mismatched++;
                $display("FAIL single c%0d: got %b expected %b", i, obs, ev[i]);
            end
            drive(iv[i]);
        end
    endtask

    task automatic test_burst_waits();
        logic [5:0] ev [7];
        logic [4:0] iv [7];
        logic [5:0] obs;
        ev = '{6'b101100, 6'b100100, 6'b100100, 6'b100100,
               6'b110100, 6'b111110, 6'b011000};
        iv = '{5'b01001, 5'b01000, 5'b01001, 5'b01000,
               5'b01000, 5'b01001, 5'b01001};
        BURST_LEN = CNT_W'(3);
        drive(5'b10001);
        for (int i = 0; i < 7; i++) begin
            tick();
            obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
            compared++;
            if (obs !== ev[i]) begin
                mismatched++;
                $display("FAIL burst_waits c%0d: got %b expected %b", i, obs, ev[i]);
            end
            drive(iv[i]);
        end
    endtask

    task automatic test_clamp();
        int lens [2];
        int want [2];
        lens = '{12, 0};
        want = '{8, 1};
        for (int t = 0; t < 2; t++) begin
            int frame_low = 0;
            int irdy_low  = 0;
            int dones     = 0;
            bit finished  = 0;
            BURST_LEN = CNT_W'(lens[t]);
            drive(5'b10000);
            for (int c = 0; c < 40 && !finished; c++) begin
                tick();
                drive(5'b01000);
                if (!FRAME) frame_low++;
                if (!IRDY) irdy_low++;
                if (DONE) dones++;
                if (c > 0 && !BUSY) finished = 1;
            end
            compared++;
            if (!finished) begin
                mismatched++;
                $display("FAIL clamp_timeout len%0d: got busy expected idle", lens[t]);
            end
            compared++;
            if (frame_low != want[t]) begin
                mismatched++;
                $display("FAIL clamp_frame len%0d: got %0d expected %0d",
                         lens[t], frame_low, want[t]);
            end
            compared++;
            if (irdy_low != want[t]) begin
                mismatched++;
                $display("FAIL clamp_irdy len%0d: got %0d expected %0d",
                         lens[t], irdy_low, want[t]);
            end
            compared++;
            if (dones != 1) begin
                mismatched++;
                $display("FAIL clamp_done len%0d: got %0d expected 1", lens[t], dones);
            end
            drive(5'b01001);
        end
    endtask

    task automatic test_priority();
        logic [5:0] ev [8];
        logic [4:0] iv [8];
        logic [5:0] obs;
        ev = '{6'b101100, 6'b110100, 6'b111110, 6'b011000,
               6'b011100, 6'b011100, 6'b011100, 6'b011000};
        iv = '{5'b01001, 5'b01000, 5'b01001, 5'b01101,
               5'b10001, 5'b10001, 5'b01011, 5'b01001};
        BURST_LEN = CNT_W'(1);
        drive(5'b10101);
        for (int i = 0; i < 8; i++) begin
            tick();
            obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
            compared++;
            if (obs !== ev[i]) begin
                mismatched++;
                $display("FAIL priority c%0d: got %b expected %b", i, obs, ev[i]);
            end
            drive(iv[i]);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ev [8];
        logic [4:0] iv [8];
        logic [5:0] obs;
        ev = '{6'b101100, 6'b110100, 6'b111110, 6'b011000,
               6'b101100, 6'b110100, 6'b111110, 6'b011000};
        iv = '{5'b10001, 5'b10000, 5'b10001, 5'b10001,
               5'b01001, 5'b01000, 5'b01001, 5'b01001};
        BURST_LEN = CNT_W'(1);
        drive(5'b10001);
        for (int i = 0; i < 8; i++) begin
            tick();
            obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
            compared++;
            if (obs !== ev[i]) begin
                mismatched++;
                $display("FAIL back_to_back c%0d: got %b expected %b", i, obs, ev[i]);
            end
            drive(iv[i]);
        end
    endtask

`ifdef PCI_MASTER_ABORT_EN
    task automatic test_abort();
        logic [5:0] ev [8];
        logic [5:0] obs;
        ev = '{6'b101100, 6'b100100, 6'b100100, 6'b100100,
               6'b100100, 6'b110100, 6'b111111, 6'b011000};
        DEVSEL = 1'b1;
        BURST_LEN = CNT_W'(4);
        drive(5'b10001);
        for (int i = 0; i < 8; i++) begin
            tick();
            obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
            compared++;
            if (obs !== ev[i]) begin
                mismatched++;
                $display("FAIL abort c%0d: got %b expected %b", i, obs, ev[i]);
            end
            drive(5'b01001);
        end
        DEVSEL = 1'b0;
    endtask
`else
    task automatic test_no_abort();
        logic [5:0] ev [10];
        logic [5:0] obs;
        ev = '{6'b101100, 6'b110100, 6'b110100, 6'b110100, 6'b110100,
               6'b110100, 6'b110100, 6'b110100, 6'b111110, 6'b011000};
        DEVSEL = 1'b1;
        BURST_LEN = CNT_W'(1);
        drive(5'b10001);
        for (int i = 0; i < 10; i++) begin
            tick();
            obs = {S_M, FRAME, IRDY, BUSY, DONE, ABORT};
            compared++;
            if (obs !== ev[i]) begin
                mismatched++;
                $display("FAIL no_abort c%0d: got %b expected %b", i, obs, ev[i]);
            end
            // Target finally responds in the seventh DATA cycle.
            drive((i == 7) ? 5'b01000 : 5'b01001);
        end
        DEVSEL = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst_waits();
        test_clamp();
        test_priority();
        test_back_to_back();
`ifdef PCI_MASTER_ABORT_EN
        test_abort();
`else
        test_no_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
